// File: rtl/cbus_arbiter_if.sv
// Cache-bus payload types and the arbiter's bus bundle.
// Types:
//   cbus_req_t  : valid, is_write, size, addr, strobe, data, len (beats-1), burst
//   cbus_resp_t : ready, last, data
// Interface cbus_arbiter_if (NUM_REQ):
//   ireqs  : requests from the upstream masters
//   iresps : responses back to the upstream masters
//   oreq   : request forwarded to memory / AXI bridge
//   oresp  : response from memory
// Modports: slave = arbiter side, master = masters + memory side.

localparam int unsigned CBUS_ADDR_W = 32;
localparam int unsigned CBUS_DATA_W = 64;
localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;
localparam int unsigned CBUS_LEN_W  = 8;

// Burst length codes: number of beats minus one.
localparam logic [CBUS_LEN_W-1:0] MLEN1  = 8'd0;
localparam logic [CBUS_LEN_W-1:0] MLEN2  = 8'd1;
localparam logic [CBUS_LEN_W-1:0] MLEN4  = 8'd3;
localparam logic [CBUS_LEN_W-1:0] MLEN8  = 8'd7;
localparam logic [CBUS_LEN_W-1:0] MLEN16 = 8'd15;

typedef struct packed {
  logic                   valid;
  logic                   is_write;
  logic [2:0]             size;
  logic [CBUS_ADDR_W-1:0] addr;
  logic [CBUS_STRB_W-1:0] strobe;
  logic [CBUS_DATA_W-1:0] data;
  logic [CBUS_LEN_W-1:0]  len;
  logic [1:0]             burst;
} cbus_req_t;

typedef struct packed {
  logic                   ready;
  logic                   last;
  logic [CBUS_DATA_W-1:0] data;
} cbus_resp_t;

interface cbus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );
endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin cbus arbiter: grants one upstream master a whole burst, forwards
// its request downstream and routes memory responses back to it alone.
// Ports:
//   clk          : rising-edge clock
//   resetn       : asynchronous active-low reset
//   bus          : cbus_arbiter_if.slave (ireqs, iresps, oreq, oresp)
//   busy         : a transaction is currently granted
//   grant_idx    : index of the current or most recent grant
//   protocol_err : sticky, set on a burst beat count that disagrees with len

module cbus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            resetn,
  cbus_arbiter_if.slave   bus,
  output logic            busy,
  output logic [IW-1:0]   grant_idx,
  output logic            protocol_err
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  int unsigned      cand;
  logic [IW-1:0]    next_ptr;
  logic [CNT_W-1:0] cur_len;

  // First valid requester at or above rr_ptr, wrapping at NUM_REQ (not 2**IW).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && bus.ireqs[IW'(cand)].valid) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign next_ptr = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
  assign cur_len  = CNT_W'(bus.ireqs[grant_idx].len);
  assign busy     = (state == BUSY);

  // Zero-latency request/response steering for the locked winner.
  always_comb begin
    bus.oreq   = '0;
    bus.iresps = '0;
    if (state == BUSY) begin
      bus.oreq              = bus.ireqs[grant_idx];
      bus.iresps[grant_idx] = bus.oresp;
    end
  end

  // Grant FSM, beat counter and sticky protocol check.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            beat_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.oresp.ready) begin
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
            if (bus.oresp.last) begin
              // beat_cnt is the count before this beat, so it must equal len.
              if (beat_cnt != cur_len) protocol_err <= 1'b1;
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else if (beat_cnt == cur_len) begin
              protocol_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with a transaction-level reference model.
module tb_cbus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned IW = 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(N)) bus ();

  cbus_req_t  [N-1:0] req_d;
  cbus_resp_t         resp_d;
  assign bus.ireqs = req_d;
  assign bus.oresp = resp_d;

  logic          busy;
  logic [IW-1:0] grant_idx;
  logic          protocol_err;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .protocol_err (protocol_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who has priority next, beats seen.
  int m_owner = -1;
  int m_next  = 0;
  int m_beats = 0;
  int m_gidx  = 0;
  bit m_err   = 1'b0;
  int m_c;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_owner = -1; m_next = 0; m_beats = 0; m_gidx = 0; m_err = 1'b0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        m_c = (m_next + i) % N;
        if (m_owner < 0 && req_d[IW'(m_c)].valid) begin
          m_owner = m_c; m_gidx = m_c; m_beats = 0;
        end
      end
    end else if (resp_d.ready) begin
      if (resp_d.last) begin
        if (m_beats != int'(req_d[IW'(m_owner)].len)) m_err = 1'b1;
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_beats == int'(req_d[IW'(m_owner)].len)) begin
        m_err = 1'b1;
      end
      if (m_beats < 511) m_beats++;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  int         resp_seen [N];
  cbus_req_t  e_oreq;
  cbus_resp_t e_resp;
  initial for (int j = 0; j < N; j++) resp_seen[j] = 0;

  always @(negedge clk) begin
    e_oreq = (m_owner >= 0) ? req_d[IW'(m_owner)] : '0;
    chk("busy", 128'(busy), 128'(m_owner >= 0));
    chk("grant_idx", 128'(grant_idx), 128'(m_gidx));
    chk("protocol_err", 128'(protocol_err), 128'(m_err));
    chk("oreq", 128'(bus.oreq), 128'(e_oreq));
    for (int j = 0; j < N; j++) begin
      e_resp = (j == m_owner) ? resp_d : '0;
      chk($sformatf("iresps%0d", j), 128'(bus.iresps[IW'(j)]), 128'(e_resp));
      if (bus.iresps[IW'(j)].ready) resp_seen[j]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    chk("grant_timeout", 128'(busy), 128'(1));
  endtask

  // Drive n ready beats; last on beat number last_at (1-based, 0 = never).
  task automatic beats(input int n, input int last_at, input logic [63:0] base);
    for (int b = 0; b < n; b++) begin
      resp_d.ready = 1'b1;
      resp_d.last  = (b == last_at - 1);
      resp_d.data  = base + 64'(b);
      tick();
    end
    resp_d = '0;
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [7:0] len);
    req_d[IW'(m)]          = '0;
    req_d[IW'(m)].valid    = 1'b1;
    req_d[IW'(m)].addr     = addr;
    req_d[IW'(m)].len      = len;
    req_d[IW'(m)].size     = 3'd3;
    req_d[IW'(m)].burst    = 2'd1;
    req_d[IW'(m)].strobe   = 8'hff;
    req_d[IW'(m)].data     = {addr, ~addr};
    req_d[IW'(m)].is_write = m[0];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int s0, s1;

  initial begin
    resetn = 1'b0;
    req_d  = '0;
    resp_d = '0;
    tick(); tick(); tick();
    resetn = 1'b1;

    // Reset state
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    chk("rst_iresps", 128'(bus.iresps), 128'(0));
    chk("rst_err", 128'(protocol_err), 128'(0));

    // Single master read
    set_req(1, 32'h8000_0000, MLEN4);
    chk("single_not_yet", 128'(busy), 128'(0));
    tick();
    chk("single_latency", 128'(bus.oreq.valid), 128'(1));
    chk("single_grant", 128'(grant_idx), 128'(1));
    chk("single_addr", 128'(bus.oreq.addr), 128'(32'h8000_0000));
    s0 = resp_seen[0]; s1 = resp_seen[1];
    beats(4, 4, 64'h100);
    req_d[1].valid = 1'b0;
    chk("single_idle_after", 128'(busy), 128'(0));
    tick();
    chk("single_beats1", 128'(resp_seen[1] - s1), 128'(4));
    chk("single_beats0", 128'(resp_seen[0] - s0), 128'(0));
    chk("single_err", 128'(protocol_err), 128'(0));

    // Contention from reset
    set_req(0, 32'h0000_1000, MLEN16);
    set_req(1, 32'h0000_2000, MLEN16);
    do_reset();
    wait_busy();
    chk("cont_first", 128'(grant_idx), 128'(0));
    beats(16, 16, 64'h200);
    req_d[0].valid = 1'b0;
    chk("cont_gap_busy", 128'(busy), 128'(0));
    chk("cont_gap_valid", 128'(bus.oreq.valid), 128'(0));
    tick();
    chk("cont_k2_busy", 128'(busy), 128'(1));
    chk("cont_second", 128'(grant_idx), 128'(1));
    beats(16, 16, 64'h300);
    req_d[1].valid = 1'b0;
    tick();
    set_req(0, 32'h0000_1100, MLEN16);
    set_req(1, 32'h0000_2100, MLEN16);
    wait_busy();
    chk("cont_rerun_first", 128'(grant_idx), 128'(0));
    beats(16, 16, 64'h400);
    req_d[0].valid = 1'b0;
    wait_busy();
    chk("cont_rerun_second", 128'(grant_idx), 128'(1));
    beats(16, 16, 64'h500);
    req_d[1].valid = 1'b0;
    tick();

    // Round-robin fairness: master 0 keeps requesting
    set_req(0, 32'h0000_3000, MLEN4);
    wait_busy();
    chk("rr_first", 128'(grant_idx), 128'(0));
    beats(2, 0, 64'h600);
    set_req(1, 32'h0000_4000, MLEN4);
    beats(2, 2, 64'h602);
    chk("rr_gap", 128'(busy), 128'(0));
    tick();
    chk("rr_switch", 128'(grant_idx), 128'(1));
    beats(4, 4, 64'h700);
    req_d[1].valid = 1'b0;
    wait_busy();
    chk("rr_back", 128'(grant_idx), 128'(0));
    beats(4, 4, 64'h800);
    req_d[0].valid = 1'b0;
    tick();

    // Protocol error: last on beat 2 of a 4-beat burst
    set_req(0, 32'h0000_5000, MLEN4);
    wait_busy();
    beats(2, 2, 64'h900);
    req_d[0].valid = 1'b0;
    tick();
    chk("perr_set", 128'(protocol_err), 128'(1));
    set_req(1, 32'h0000_6000, MLEN2);
    wait_busy();
    beats(2, 2, 64'ha00);
    req_d[1].valid = 1'b0;
    tick();
    chk("perr_sticky", 128'(protocol_err), 128'(1));

    // Reset mid-burst on beat 3 of 8
    set_req(0, 32'h0000_7000, MLEN8);
    wait_busy();
    beats(2, 0, 64'hb00);
    resp_d.ready = 1'b1;
    resp_d.data  = 64'hb02;
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_oreq", 128'(bus.oreq), 128'(0));
    resp_d = '0;
    req_d[0].valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk("mid_rst_err_clear", 128'(protocol_err), 128'(0));
    set_req(1, 32'h0000_8000, MLEN1);
    wait_busy();
    chk("post_rst_grant", 128'(grant_idx), 128'(1));
    beats(1, 1, 64'hc00);
    req_d[1].valid = 1'b0;
    chk("single_beat_done", 128'(busy), 128'(0));
    tick();
    chk("single_beat_err", 128'(protocol_err), 128'(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter that shares the single cache-bus (cbus) port to memory between several cbus masters, such as the instruction cache, the data cache and uncached bypass paths. It locks the winner for one whole burst transaction, from grant to the beat where `ready && last`. It forwards the winner's `cbus_req_t` downstream and routes `cbus_resp_t` back to that requester only. It sits between the caches and the AXI bridge, and it checks burst beat counts against `len`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of upstream cbus masters; must be ≥ 2 and need not be a power of 2.
- `IW`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk`  in  1  single clock domain, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireqs`  in  `cbus_req_t [NUM_REQ]`  requests from the masters.
- `iresps`  out  `cbus_resp_t [NUM_REQ]`  responses to the masters.
- `oreq`  out  `cbus_req_t`  request to memory/AXI bridge.
- `oresp`  in  `cbus_resp_t`  response from memory.
- `busy`  out  1  a transaction is granted (state BUSY).
- `grant_idx`  out  IW  index of the current or most recent grant.
- `protocol_err`  out  1  sticky flag: beat-count mismatch seen.

## Operation
- **States:** IDLE and BUSY. Registers: `state`, `grant_idx`, `rr_ptr` (IW bits), `beat_cnt` (9 bits), `protocol_err`.
- **IDLE:**
  - `oreq` = all zeros.
  - All `iresps` = zeros.
  - If any `ireqs[i].valid`, select the first valid index searching upward from `rr_ptr`, wrapping from NUM_REQ-1 to 0.
  - On the clock edge: `grant_idx` ← winner, `beat_cnt` ← 0, state ← BUSY.
- **BUSY:**
  - `oreq` = `ireqs[grant_idx]` combinationally. All fields pass through, including per-beat `data` and `strobe`.
  - `iresps[grant_idx]` = `oresp`. Every other `iresps[j]` = zeros (`ready`=0, `last`=0, `data`=0).
- **Beat counting:** each cycle with `oresp.ready`, `beat_cnt` increments.
- **End of transaction:** when `oresp.ready && oresp.last`:
  - state ← IDLE.
  - `rr_ptr` ← `grant_idx`+1, wrapping NUM_REQ-1 → 0.
- **Grant lock:** the grant is held until `ready && last`, even if the granted master drops `valid` mid-burst. `oreq.valid` simply follows that master. The arbiter never aborts a transaction.
- **Protocol check:** `protocol_err` is set (and stays set) in either case:
  - `ready && last` arrives with `beat_cnt` ≠ `oreq.len` (the count before the increment).
  - `ready` arrives without `last` when `beat_cnt` = `oreq.len`.
  - The check uses `len` as latched from the forwarded request in the same cycle.
- **Unused fields:** `burst`, `size` and `is_write` are forwarded unchanged and not interpreted.
- **Non-granted masters:** a master that asserts `valid` while not granted sees zero responses and must hold its request; no request is lost.

## Timing
- **Reset** (asynchronous, `resetn`=0):
  - state=IDLE, `rr_ptr`=0, `grant_idx`=0, `beat_cnt`=0, `protocol_err`=0.
  - `busy`=0, `oreq`=0, all `iresps`=0.
  - Reset mid-burst abandons the transaction immediately; downstream must also be reset.
- **Grant latency:** a request seen valid in IDLE cycle c appears on `oreq` in cycle c+1.
- **Responses:** combinational, zero-cycle path from `oresp` to `iresps[grant_idx]` in BUSY.
- **After the last beat:**
  - Last beat in cycle k puts the arbiter in IDLE in cycle k+1, with `oreq.valid`=0.
  - The earliest next grant is driven in cycle k+2. There is one guaranteed idle cycle between transactions.
- **Simultaneous requests:** the index closest at or above `rr_ptr` wins.
  - After reset with both valid, index 0 wins first, then 1.
- **Back-to-back same master:** a master that re-requests immediately after its own transaction is granted again only if no other master is valid, or when the rotation returns to it.
- **Single-beat transfer:** `len`=`MLEN1` with `ready && last` in the first BUSY cycle is legal. BUSY lasts exactly 1 cycle.
- **Overflow:** `beat_cnt` saturates at 511; no wrap.

## Test plan
- **Reset state:** hold `resetn`=0, then release. `busy`=0, `oreq.valid`=0, all `iresps`=0, `protocol_err`=0.
- **Single master read:** `ireqs[1]` has valid, `addr`=0x8000_0000, `len`=`MLEN4`; memory returns 4 ready beats, the last with `last`.
  - `oreq` valid 1 cycle after the request; `grant_idx`=1.
  - `iresps[1]` mirrors all 4 beats; `iresps[0]` stays 0.
  - IDLE the cycle after `last`; `protocol_err`=0.
- **Contention:** both masters valid from reset, each with `len`=`MLEN16`.
  - Master 0 gets 16 beats, then one idle cycle, then master 1 is granted at k+2.
  - Rerun with both valid again: master 0 is granted again, since `rr_ptr` wrapped to 0.
- **Round-robin fairness:** master 0 requests continuously; master 1 raises `valid` during master 0's burst.
  - The next grant after master 0's `last` goes to master 1, never master 0 twice in a row.
- **Protocol error:** `len`=`MLEN4`, memory asserts `last` on beat 2. `protocol_err`=1 and stays 1 through later clean transactions until reset.
- **Reset mid-burst:** drop `resetn` on beat 3 of 8. Same cycle: `busy`=0 and `oreq`=0. After release, a new request from master 1 is granted normally.
